diferential_muxpga_ctrl: RTL and testbench
==========================================

# diferential_muxpga_ctrl

Host-side sequencer for the diferential_muxpga fabric. It takes a configuration bitstream of nibbles over a valid/ready stream and shifts it into the fabric with the shift command. It then runs a requested number of evaluation cycles with a fixed input nibble and returns the fabric's 8-bit output over a valid/ready result channel. It sits between a host bus adapter and the fabric's 8-bit pin interface, and it is the only driver of the fabric's command and nibble pins.

## Interface
- CFG_NIBBLES, 24: configuration nibbles per full load (2 per cell, 12 cells).
- RUN_W, 8: width of the run-length field.

- clk  in  1  clock; fabric runs on the same clock.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  configuration nibble valid.
- cfg_ready  out  1  configuration nibble accepted when both are high.
- cfg_data  in  4  configuration nibble; the first nibble accepted ends up deepest in the chain.
- run_valid  in  1  run request valid.
- run_ready  out  1  run request accepted when both are high.
- run_len  in  RUN_W  number of evaluation cycles; 0 means 2^RUN_W.
- run_nibble  in  4  fabric input nibble held for the whole run.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed when both are high.
- res_data  out  8  fabric output sampled on the last evaluation cycle.
- busy  out  1  high in any state other than IDLE.
- loaded  out  1  a complete CFG_NIBBLES load has finished since reset or since the last load start.
- fab_cmd  out  2  to fabric pins [7:6].
- fab_nibble  out  4  to fabric pins [5:2].
- fab_reset  out  1  to fabric pin [1]; active-high, synchronous to the fabric.
- fab_out  in  8  fabric output pins.

## Operation
- Commands come from the package: CMD_SHIFT=0, CMD_RUN=1, CMD_HOLD=2. CMD_HOLD freezes the configuration chain and the cell registers.
- All fab_* outputs are registered.
- FSM states: INIT, IDLE, LOAD, RUN, DONE.
- INIT
  - Entered from reset; lasts exactly 1 cycle after reset_n deasserts.
  - fab_reset=1, fab_cmd=CMD_HOLD.
  - Next state: IDLE.
- IDLE
  - cfg_ready=1.
  - run_ready=loaded.
  - If run_valid and run_ready are both high, the run request wins over any simultaneous cfg_valid. It captures run_len and run_nibble and goes to RUN.
  - Else if cfg_valid is high, the nibble is accepted. This clears loaded, sets cnt=1 and goes to LOAD.
- LOAD
  - cfg_ready=1, run_ready=0.
  - Each accepted nibble drives fab_cmd=CMD_SHIFT and fab_nibble=cfg_data in the next cycle, then increments cnt.
  - A cycle with no handshake drives fab_cmd=CMD_HOLD, so gaps in the stream are legal.
  - When cnt reaches CFG_NIBBLES on an accept, set loaded=1 and go to IDLE.
- RUN
  - fab_cmd=CMD_RUN and fab_nibble=run_nibble for exactly N cycles, where N = run_len, or 2^RUN_W when run_len=0.
  - res_data is sampled from fab_out at the clock edge that ends the N-th CMD_RUN cycle.
  - Next state: DONE.
- DONE
  - fab_cmd=CMD_HOLD; res_valid=1.
  - res_data stays stable until res_ready is high.
  - Then go to IDLE. loaded is unchanged.
- cnt is $clog2(CFG_NIBBLES+1) bits. The run counter is RUN_W+1 bits. Neither counter wraps.
- Asynchronous reset mid-operation aborts any load or run immediately. loaded=0; a partial load must be reloaded in full.

## Timing
- Reset values: cfg_ready=0, run_ready=0, res_valid=0, res_data=0, busy=0, loaded=0, fab_cmd=CMD_HOLD, fab_nibble=0, fab_reset=1.
- cfg_ready, run_ready and busy are decoded from registered state only. They do not depend on the same cycle's valid inputs.
- Config throughput: 1 nibble per cycle. A full load takes at least CFG_NIBBLES cycles, plus 1 cycle of fab_* lag.
- Run latency: res_valid rises N+1 cycles after the run handshake edge. fab_cmd is CMD_RUN for N consecutive cycles, starting 1 cycle after the handshake.
- res_valid held low by res_ready stalls in DONE indefinitely with fab_cmd=CMD_HOLD, so fabric state is frozen.
- Back-to-back runs: the earliest next run handshake is the cycle after the DONE handshake.

## Structure
- Package diferential_muxpga_pkg holds:
  - the state enum;
  - CMD_SHIFT, CMD_RUN and CMD_HOLD;
  - CFG_NIBBLES_DEFAULT = 2*(ROWS-1)*COLS.
- Single module; no sub-module needed.
- The top-level wrapper maps {fab_cmd, fab_nibble, fab_reset, clk} onto the fabric's io_in and fab_out onto io_out.

## Test plan
- Reset released -> INIT for 1 cycle with fab_reset=1 -> IDLE with cfg_ready=1, run_ready=0, loaded=0, fab_cmd=2.
- Stream 24 nibbles 0x0..0x7 repeating, back-to-back -> 24 fab_cmd=0 cycles carrying the same nibbles in order, 1 cycle delayed. loaded=1 after the 24th accept.
- Same load with cfg_valid toggling every other cycle -> fab_cmd=2 in each gap, and still exactly 24 shift cycles.
- Load all cells as OR gates fed from the input row, then run_len=3 with run_nibble=0xA -> fab_cmd=1 for 3 cycles, res_valid 4 cycles after the handshake, res_data=0xAA.
- In IDLE with loaded=1, assert cfg_valid and run_valid together -> run accepted, no nibble consumed, loaded stays 1. With run_len=0 -> exactly 256 CMD_RUN cycles.
- Hold res_ready=0 for 10 cycles in DONE -> res_data stable and fab_cmd=2 throughout. Pull reset_n low mid-LOAD at cnt=10 -> all outputs at reset values and loaded=0.

Source files
------------

// File: rtl/diferential_muxpga_pkg.sv
// Shared types and constants for the diferential_muxpga host sequencer.
//   ROWS/COLS             : fabric geometry
//   CFG_NIBBLES_DEFAULT   : nibbles in one full configuration load
//   RUN_W_DEFAULT         : default run-length field width
//   fab_cmd_t             : fabric command pin encoding
//   state_t               : sequencer FSM states
package diferential_muxpga_pkg;

    localparam int unsigned ROWS                = 4;
    localparam int unsigned COLS                = 4;
    localparam int unsigned CFG_NIBBLES_DEFAULT = 2 * (ROWS - 1) * COLS;
    localparam int unsigned RUN_W_DEFAULT       = 8;

    typedef enum logic [1:0] {
        CMD_SHIFT = 2'd0,
        CMD_RUN   = 2'd1,
        CMD_HOLD  = 2'd2
    } fab_cmd_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/diferential_muxpga_ctrl_if.sv
// Host-side bundle of the sequencer: config stream, run request, result
// channel and status flags.
//   master : host bus adapter side
//   slave  : sequencer side
interface diferential_muxpga_ctrl_if
    import diferential_muxpga_pkg::*;
#(
    parameter int unsigned RUN_W = RUN_W_DEFAULT
) ();

    logic             cfg_valid;
    logic             cfg_ready;
    logic [3:0]       cfg_data;

    logic             run_valid;
    logic             run_ready;
    logic [RUN_W-1:0] run_len;
    logic [3:0]       run_nibble;

    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_data;

    logic             busy;
    logic             loaded;

    modport master (
        output cfg_valid, cfg_data, run_valid, run_len, run_nibble, res_ready,
        input  cfg_ready, run_ready, res_valid, res_data, busy, loaded
    );

    modport slave (
        input  cfg_valid, cfg_data, run_valid, run_len, run_nibble, res_ready,
        output cfg_ready, run_ready, res_valid, res_data, busy, loaded
    );

endinterface

// File: rtl/diferential_muxpga_ctrl.sv
// Host-side sequencer for the diferential_muxpga fabric: shifts a nibble
// bitstream into the fabric, runs N evaluation cycles with a fixed input
// nibble, and returns the fabric output.
//   clk, reset_n : clock (shared with fabric), async active-low reset
//   host         : config stream, run request, result channel, busy/loaded
//   fab_cmd      : fabric pins [7:6]
//   fab_nibble   : fabric pins [5:2]
//   fab_reset    : fabric pin  [1], active high
//   fab_out      : fabric output pins
module diferential_muxpga_ctrl
    import diferential_muxpga_pkg::*;
#(
    parameter int unsigned CFG_NIBBLES = CFG_NIBBLES_DEFAULT,
    parameter int unsigned RUN_W       = RUN_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    diferential_muxpga_ctrl_if.slave host,
    output logic [1:0]              fab_cmd,
    output logic [3:0]              fab_nibble,
    output logic                    fab_reset,
    input  logic [7:0]              fab_out
);

    localparam int unsigned CNT_W     = $clog2(CFG_NIBBLES + 1);
    localparam int unsigned RUN_CNT_W = RUN_W + 1;
    localparam logic [RUN_CNT_W-1:0] RUN_MAX = RUN_CNT_W'(1) << RUN_W;

    state_t                 state_q,      state_d;
    logic [CNT_W-1:0]       cnt_q,        cnt_d;
    logic [RUN_CNT_W-1:0]   run_cnt_q,    run_cnt_d;
    logic                   loaded_q,     loaded_d;
    logic                   res_valid_q,  res_valid_d;
    logic [7:0]             res_data_q,   res_data_d;
    logic                   cfg_ready_q,  cfg_ready_d;
    logic                   run_ready_q,  run_ready_d;
    logic                   busy_q,       busy_d;
    fab_cmd_t               fab_cmd_q,    fab_cmd_d;
    logic [3:0]             fab_nibble_q, fab_nibble_d;
    logic                   fab_reset_q,  fab_reset_d;

    logic cfg_hs;
    logic run_hs;

    assign cfg_hs = host.cfg_valid && cfg_ready_q;
    assign run_hs = host.run_valid && run_ready_q;

    // Next-state and next-output decode; fabric idles in HOLD by default.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        run_cnt_d    = run_cnt_q;
        loaded_d     = loaded_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        fab_cmd_d    = CMD_HOLD;
        fab_nibble_d = fab_nibble_q;
        fab_reset_d  = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                // A run request takes priority over a simultaneous nibble.
                if (run_hs) begin
                    state_d      = ST_RUN;
                    run_cnt_d    = (host.run_len == '0) ? RUN_MAX
                                                        : RUN_CNT_W'(host.run_len);
                    fab_cmd_d    = CMD_RUN;
                    fab_nibble_d = host.run_nibble;
                end else if (cfg_hs) begin
                    state_d      = ST_LOAD;
                    loaded_d     = 1'b0;
                    cnt_d        = CNT_W'(1);
                    fab_cmd_d    = CMD_SHIFT;
                    fab_nibble_d = host.cfg_data;
                end
            end
            ST_LOAD: begin
                if (cfg_hs) begin
                    fab_cmd_d    = CMD_SHIFT;
                    fab_nibble_d = host.cfg_data;
                    cnt_d        = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(CFG_NIBBLES - 1)) begin
                        loaded_d = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                // Output is captured as the last CMD_RUN cycle ends; the
                // following cycle holds the fabric while res_valid is raised.
                if (run_cnt_q > RUN_CNT_W'(1)) begin
                    fab_cmd_d = CMD_RUN;
                    run_cnt_d = run_cnt_q - RUN_CNT_W'(1);
                end else if (run_cnt_q == RUN_CNT_W'(1)) begin
                    res_data_d = fab_out;
                    run_cnt_d  = '0;
                end else begin
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (host.res_ready && res_valid_q) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        cfg_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
        run_ready_d = (state_d == ST_IDLE) && loaded_d;
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            run_cnt_q    <= '0;
            loaded_q     <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            cfg_ready_q  <= 1'b0;
            run_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            fab_cmd_q    <= CMD_HOLD;
            fab_nibble_q <= '0;
            fab_reset_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            run_cnt_q    <= run_cnt_d;
            loaded_q     <= loaded_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            cfg_ready_q  <= cfg_ready_d;
            run_ready_q  <= run_ready_d;
            busy_q       <= busy_d;
            fab_cmd_q    <= fab_cmd_d;
            fab_nibble_q <= fab_nibble_d;
            fab_reset_q  <= fab_reset_d;
        end
    end

    assign host.cfg_ready = cfg_ready_q;
    assign host.run_ready = run_ready_q;
    assign host.res_valid = res_valid_q;
    assign host.res_data  = res_data_q;
    assign host.busy      = busy_q;
    assign host.loaded    = loaded_q;
    assign fab_cmd        = fab_cmd_q;
    assign fab_nibble     = fab_nibble_q;
    assign fab_reset      = fab_reset_q;

endmodule

// File: tb/tb_diferential_muxpga_ctrl.sv
// Self-checking bench for diferential_muxpga_ctrl with a behavioural
// fabric stub: SHIFT pushes a nibble into an 8-bit register, RUN adds
// {nibble,nibble} per evaluation cycle, and the output pins show the value
// being produced by the current evaluation.
module tb_diferential_muxpga_ctrl;
    import diferential_muxpga_pkg::*;

    localparam int unsigned N_CFG = CFG_NIBBLES_DEFAULT;
    localparam int unsigned RW    = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] fab_cmd;
    logic [3:0] fab_nibble;
    logic       fab_reset;
    logic [7:0] fab_out;
    logic [7:0] acc;

    diferential_muxpga_ctrl_if #(.RUN_W(RW)) host_if ();

    diferential_muxpga_ctrl #(.CFG_NIBBLES(N_CFG), .RUN_W(RW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .host       (host_if),
        .fab_cmd    (fab_cmd),
        .fab_nibble (fab_nibble),
        .fab_reset  (fab_reset),
        .fab_out    (fab_out)
    );

    always #5 clk = ~clk;

    // Fabric stub.
    always @(posedge clk) begin
        if (fab_reset)                 acc <= 8'h00;
        else if (fab_cmd == CMD_SHIFT) acc <= {acc[3:0], fab_nibble};
        else if (fab_cmd == CMD_RUN)   acc <= acc + {fab_nibble, fab_nibble};
    end
    assign fab_out = acc + ((fab_cmd == CMD_RUN) ? {fab_nibble, fab_nibble} : 8'h00);

    // Pin monitor, sampling the cycle that is ending at each rising edge.
    int unsigned cyc = 0;
    int unsigned n_shift = 0;
    int unsigned n_run = 0;
    int unsigned n_hold_busy = 0;
    logic [3:0]  shift_q[$];

    always @(posedge clk) begin
        cyc++;
        if (reset_n) begin
            if (fab_cmd == CMD_SHIFT) begin
                n_shift++;
                shift_q.push_back(fab_nibble);
            end
            if (fab_cmd == CMD_RUN) n_run++;
            if (fab_cmd == CMD_HOLD && host_if.busy) n_hold_busy++;
        end
    end

    int         errors = 0;
    int         checks = 0;
    logic [7:0] fab_model = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cfg_ready"},  32'(host_if.cfg_ready), 32'(0));
        check({tag, "_run_ready"},  32'(host_if.run_ready), 32'(0));
        check({tag, "_res_valid"},  32'(host_if.res_valid), 32'(0));
        check({tag, "_res_data"},   32'(host_if.res_data),  32'(0));
        check({tag, "_busy"},       32'(host_if.busy),      32'(0));
        check({tag, "_loaded"},     32'(host_if.loaded),    32'(0));
        check({tag, "_fab_cmd"},    32'(fab_cmd),           32'(CMD_HOLD));
        check({tag, "_fab_nibble"}, 32'(fab_nibble),        32'(0));
        check({tag, "_fab_reset"},  32'(fab_reset),         32'(1));
    endtask

    // Full load; called at a falling edge, returns at a falling edge.
    task automatic do_load(input bit gaps, input bit rnd, input string tag);
        logic [3:0]  sent[$];
        logic [3:0]  nib;
        int unsigned sh0, hb0;
        int          base, i, guard, nbad;
        sh0   = n_shift;
        hb0   = n_hold_busy;
        base  = shift_q.size();
        i     = 0;
        guard = 0;
        nbad  = 0;
        while (i < int'(N_CFG) && guard < 4 * int'(N_CFG)) begin
            if (guard != 0) @(negedge clk);
            guard++;
            if (gaps && (guard % 2 == 0)) begin
                host_if.cfg_valid = 1'b0;
            end else begin
                nib = rnd ? 4'($urandom) : 4'(i % 8);
                host_if.cfg_valid = 1'b1;
                host_if.cfg_data  = nib;
                if (host_if.cfg_ready) begin
                    sent.push_back(nib);
                    i++;
                end
            end
        end
        @(negedge clk);
        host_if.cfg_valid = 1'b0;
        check({tag, "_accepted"}, 32'(i), 32'(N_CFG));
        check({tag, "_loaded"},   32'(host_if.loaded), 32'(1));
        check({tag, "_busy"},     32'(host_if.busy),   32'(0));
        repeat (2) @(negedge clk);
        check({tag, "_shift_cycles"}, 32'(n_shift - sh0), 32'(N_CFG));
        check({tag, "_hold_gaps"},    32'(n_hold_busy - hb0), gaps ? 32'(N_CFG - 1) : 32'(0));
        for (int k = 0; k < int'(N_CFG); k++)
            if (shift_q.size() <= base + k || shift_q[base + k] !== sent[k]) nbad++;
        check({tag, "_shift_order_bad"}, 32'(nbad), 32'(0));
        if (sent.size() >= 2) fab_model = {sent[sent.size() - 2], sent[sent.size() - 1]};
    endtask

    // Run request presented at the current falling edge; returns at the
    // falling edge just after the result handshake.
    task automatic do_run(input logic [7:0] len, input logic [3:0] nib, input bit with_cfg,
                          input int stall, input string tag);
        int unsigned n, r0, sh0, c_hs;
        int          guard, bad;
        logic [31:0] tmp;
        logic [7:0]  exp, held;
        n = (len == 8'd0) ? 256 : int'(len);
        host_if.run_valid  = 1'b1;
        host_if.run_len    = len;
        host_if.run_nibble = nib;
        if (with_cfg) begin
            host_if.cfg_valid = 1'b1;
            host_if.cfg_data  = 4'($urandom);
        end
        check({tag, "_run_ready"}, 32'(host_if.run_ready), 32'(1));
        r0   = n_run;
        sh0  = n_shift;
        c_hs = cyc + 1;
        @(negedge clk);
        host_if.run_valid = 1'b0;
        host_if.cfg_valid = 1'b0;
        guard = 0;
        while (!host_if.res_valid && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_latency"}, 32'(cyc - c_hs), 32'(n + 1));
        tmp = 32'(fab_model) + 32'(n) * 32'({nib, nib});
        exp = tmp[7:0];
        check({tag, "_res_data"},   32'(host_if.res_data), 32'(exp));
        check({tag, "_run_cycles"}, 32'(n_run - r0),       32'(n));
        check({tag, "_no_nibble"},  32'(n_shift - sh0),    32'(0));
        check({tag, "_loaded"},     32'(host_if.loaded),   32'(1));
        fab_model = exp;
        held = host_if.res_data;
        bad  = 0;
        repeat (stall) begin
            @(negedge clk);
            if (host_if.res_data !== held || fab_cmd !== CMD_HOLD || host_if.res_valid !== 1'b1)
                bad++;
        end
        check({tag, "_stall_bad"}, 32'(bad), 32'(0));
        host_if.res_ready = 1'b1;
        @(negedge clk);
        host_if.res_ready = 1'b0;
        check({tag, "_res_valid_drop"}, 32'(host_if.res_valid), 32'(0));
        check({tag, "_idle_busy"},      32'(host_if.busy),      32'(0));
        check({tag, "_idle_run_ready"}, 32'(host_if.run_ready), 32'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        host_if.cfg_valid  = 1'b0;
        host_if.cfg_data   = 4'h0;
        host_if.run_valid  = 1'b0;
        host_if.run_len    = 8'h00;
        host_if.run_nibble = 4'h0;
        host_if.res_ready  = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset_n = 1'b1;
        #1;
        check("init_fab_reset", 32'(fab_reset),         32'(1));
        check("init_cfg_ready", 32'(host_if.cfg_ready), 32'(0));
        @(negedge clk);
        check("idle_cfg_ready", 32'(host_if.cfg_ready), 32'(1));
        check("idle_run_ready", 32'(host_if.run_ready), 32'(0));
        check("idle_loaded",    32'(host_if.loaded),    32'(0));
        check("idle_fab_cmd",   32'(fab_cmd),           32'(CMD_HOLD));
        check("idle_fab_reset", 32'(fab_reset),         32'(0));
        check("idle_busy",      32'(host_if.busy),      32'(0));
        fab_model = 8'h00;

        do_load(1'b0, 1'b0, "load_b2b");
        do_load(1'b1, 1'b0, "load_gap");
        do_run(8'd3, 4'hA, 1'b0, 0, "run3");
        do_run(8'd0, 4'h5, 1'b1, 10, "run256");

        for (int t = 0; t < 4; t++) begin
            do_load(1'($urandom_range(0, 1)), 1'b1, $sformatf("rload%0d", t));
            do_run(8'($urandom_range(1, 20)), 4'($urandom), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 5)), $sformatf("rrun%0d", t));
            do_run(8'($urandom_range(1, 20)), 4'($urandom), 1'b0, 0, $sformatf("b2b%0d", t));
        end

        // Partial load of 10 nibbles, then asynchronous reset.
        for (int k = 0; k < 10; k++) begin
            host_if.cfg_valid = 1'b1;
            host_if.cfg_data  = 4'($urandom);
            @(negedge clk);
        end
        host_if.cfg_valid = 1'b0;
        check("mid_load_loaded", 32'(host_if.loaded), 32'(0));
        check("mid_load_busy",   32'(host_if.busy),   32'(1));
        reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rec_cfg_ready", 32'(host_if.cfg_ready), 32'(1));
        check("rec_run_ready", 32'(host_if.run_ready), 32'(0));
        check("rec_loaded",    32'(host_if.loaded),    32'(0));
        fab_model = 8'h00;
        do_load(1'b0, 1'b1, "rec_load");
        do_run(8'd7, 4'h3, 1'b0, 2, "rec_run");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
